// File: rtl/pool_row_packer.sv
// rtl/pool_row_packer.sv - 2x2/stride-2 max pooling with per-lane word packing into next-layer FIFOs
//
// Purpose: consumes a raster-order pixel stream (one pixel per lane per beat),
// max-pools 2x2 windows, packs IW pooled pixels per lane into one word and
// writes it to the next layer's input FIFOs under prog_full back-pressure.
//
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   in_valid/in_ready    input beat handshake
//   in_data              one pixel per lane, lane l at [l*DATA_WIDTH +: DATA_WIDTH]
//   out_wren/out_din     write strobe and packed word (lane l slot k at (l*IW+k)*DATA_WIDTH)
//   out_full             OR of downstream prog_full
//   row_done/frame_done  pulses after the last word of a pooled row / frame
module pool_row_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 3,
    parameter int IW         = 7,
    parameter int ROW_LEN    = 50,
    parameter int NUM_ROWS   = 50
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]      in_data,
    output logic                             out_wren,
    output logic [LANES*IW*DATA_WIDTH-1:0]   out_din,
    input  logic                             out_full,
    output logic                             row_done,
    output logic                             frame_done
);

    localparam int HALF   = ROW_LEN / 2;
    localparam int COL_W  = $clog2(ROW_LEN);
    localparam int ROW_W  = $clog2(NUM_ROWS);
    localparam int P_W    = $clog2(IW);
    localparam int WORD_W = LANES * IW * DATA_WIDTH;

    typedef enum logic [1:0] {S_EVEN, S_ODD, S_FLUSH, S_HOLD} state_t;

    state_t                          state_q, state_d;
    logic [COL_W-1:0]                col_q;
    logic [ROW_W-1:0]                row_q;
    logic [P_W-1:0]                  p_q;
    logic [LANES*DATA_WIDTH-1:0]     h_q;
    logic [WORD_W-1:0]               pack_q;
    logic [WORD_W-1:0]               out_din_q;
    logic                            pend_q;
    logic                            pend_last_q;
    logic                            pend_frame_q;
    logic                            row_done_q;
    logic                            frame_done_q;
    logic [DATA_WIDTH-1:0]           lb_q [LANES][HALF];

    logic [DATA_WIDTH-1:0]           hmax   [LANES];
    logic [DATA_WIDTH-1:0]           pooled [LANES];
    logic [WORD_W-1:0]               word_ins;
    logic [COL_W-2:0]                lb_idx;
    logic                            accept;
    logic                            col_last;
    logic                            row_last;
    logic                            p_last;
    logic                            odd_beat;
    logic                            word_done;
    logic                            write_now;
    logic                            stalled;

    assign lb_idx    = col_q[COL_W-1:1];
    assign col_last  = (col_q == COL_W'(ROW_LEN - 1));
    assign row_last  = (row_q == ROW_W'(NUM_ROWS - 1));
    assign p_last    = (p_q == P_W'(IW - 1));
    // A pending word that cannot be written this cycle blocks input immediately,
    // before the registered state has reached S_HOLD.
    assign stalled   = pend_q & out_full;
    assign in_ready  = rstn & ((state_q == S_EVEN) | (state_q == S_ODD)) & ~stalled;
    assign accept    = in_valid & in_ready;
    assign odd_beat  = accept & (state_q == S_ODD) & col_q[0];
    assign word_done = odd_beat & (p_last | col_last);
    assign write_now = pend_q & ~out_full;

    assign out_wren   = rstn & write_now;
    assign out_din    = out_din_q;
    assign row_done   = row_done_q;
    assign frame_done = frame_done_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [DATA_WIDTH-1:0] pix;
        logic [DATA_WIDTH-1:0] hreg;
        logic [DATA_WIDTH-1:0] lb_rd;
        assign pix       = in_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign hreg      = h_q[g*DATA_WIDTH +: DATA_WIDTH];
        assign lb_rd     = lb_q[g][lb_idx];
        assign hmax[g]   = (hreg > pix) ? hreg : pix;
        assign pooled[g] = (hmax[g] > lb_rd) ? hmax[g] : lb_rd;

        // Even rows park the horizontal max; the odd row reads it back.
        always_ff @(posedge clk) begin
            if (accept && state_q == S_EVEN && col_q[0]) begin
                lb_q[g][lb_idx] <= hmax[g];
            end
        end
    end

    always_comb begin
        word_ins = pack_q;
        for (int l = 0; l < LANES; l++) begin
            word_ins[(l*IW + int'(p_q))*DATA_WIDTH +: DATA_WIDTH] = pooled[l];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EVEN: begin
                if (stalled) state_d = S_HOLD;
                else if (accept && col_last) state_d = S_ODD;
            end
            S_ODD: begin
                if (stalled) state_d = S_HOLD;
                else if (accept && col_last) state_d = p_last ? S_EVEN : S_FLUSH;
            end
            S_FLUSH: begin
                state_d = out_full ? S_HOLD : S_EVEN;
            end
            S_HOLD: begin
                // Row counter has already advanced past a finished row, so its
                // parity tells us where to resume.
                if (!out_full) state_d = row_q[0] ? S_ODD : S_EVEN;
            end
            default: state_d = S_EVEN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_EVEN;
            col_q        <= '0;
            row_q        <= '0;
            p_q          <= '0;
            h_q          <= '0;
            pack_q       <= '0;
            out_din_q    <= '0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            pend_frame_q <= 1'b0;
            row_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_done_q   <= write_now & pend_last_q;
            frame_done_q <= write_now & pend_frame_q;
            if (write_now) pend_q <= 1'b0;

            if (accept) begin
                if (!col_q[0]) h_q <= in_data;
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end

            if (word_done) begin
                out_din_q    <= word_ins;
                pend_q       <= 1'b1;
                pend_last_q  <= col_last;
                pend_frame_q <= col_last & row_last;
                pack_q       <= '0;
                p_q          <= '0;
            end else if (odd_beat) begin
                pack_q <= word_ins;
                p_q    <= p_q + P_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pool_row_packer.sv
// tb/tb_pool_row_packer.sv - directed self-checking bench for pool_row_packer
module tb_pool_row_packer;

    localparam int DW = 8;
    localparam int LN = 3;
    localparam int IWP = 7;
    localparam int RL = 50;
    localparam int NR = 50;
    localparam int WW = LN*IWP*DW;
    localparam int FRAME_PIX = RL*NR;
    localparam int WPR = 4;

    logic           clk = 1'b0;
    logic           rstn;
    logic           in_valid;
    logic           in_ready;
    logic [LN*DW-1:0] in_data;
    logic           out_wren;
    logic [WW-1:0]  out_din;
    logic           out_full;
    logic           row_done;
    logic           frame_done;

    int total = 0;
    int bad = 0;

    logic [WW-1:0] words[$];
    int rd_cnt = 0;
    int fd_cnt = 0;
    int fd_bad = 0;
    int fd_rd[$];

    pool_row_packer #(.DATA_WIDTH(DW), .LANES(LN), .IW(IWP), .ROW_LEN(RL), .NUM_ROWS(NR)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_wren(out_wren), .out_din(out_din), .out_full(out_full),
        .row_done(row_done), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_wren) words.push_back(out_din);
        if (row_done) rd_cnt++;
        if (frame_done) begin
            fd_cnt++;
            fd_rd.push_back(rd_cnt);
            if (!row_done) fd_bad++;
        end
    end

    task automatic check_eq(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int pix(input int mode, input int lane, input int r, input int c);
        if (mode == 0) return (c + r*RL) % 256;
        if (lane == 0) return 255;
        if (lane == 1) return 0;
        return ((r + c) % 2 != 0) ? 200 : 0;
    endfunction

    // Golden word i of a frame: plain 2x2 window max, unfilled slots zero.
    function automatic logic [WW-1:0] gold_word(input int mode, input int i);
        logic [WW-1:0] w;
        int r2, c2, v, m;
        w = '0;
        r2 = i / WPR;
        for (int l = 0; l < LN; l++) begin
            for (int k = 0; k < IWP; k++) begin
                c2 = (i % WPR)*IWP + k;
                if (c2 < RL/2) begin
                    m = 0;
                    for (int dr = 0; dr < 2; dr++)
                        for (int dc = 0; dc < 2; dc++) begin
                            v = pix(mode, l, 2*r2 + dr, 2*c2 + dc);
                            if (v > m) m = v;
                        end
                    v = m;
                    w[(l*IWP + k)*DW +: DW] = v[DW-1:0];
                end
            end
        end
        return w;
    endfunction

    function automatic logic [WW-1:0] wget(input int i);
        if (i < words.size()) return words[i];
        return 'x;
    endfunction

    task automatic clear_obs();
        words.delete();
        fd_rd.delete();
        rd_cnt = 0;
        fd_cnt = 0;
        fd_bad = 0;
    endtask

    // Feed npix pixels of pattern mode from frame origin; gap = percent idle beats.
    task automatic feed(input int mode, input int npix, input int gap);
        int n, guard, r, c, v;
        n = 0;
        guard = 0;
        while (n < npix) begin
            @(negedge clk);
            r = (n / RL) % NR;
            c = n % RL;
            in_valid = (gap == 0) || ($urandom_range(0, 99) >= gap);
            for (int l = 0; l < LN; l++) begin
                v = pix(mode, l, r, c);
                in_data[l*DW +: DW] = v[DW-1:0];
            end
            #1;
            if (in_valid && in_ready) n++;
            guard++;
            if (guard > npix*4 + 2000) begin
                check_eq("feed_timeout", WW'(n), WW'(npix));
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int mode, input int base);
        for (int i = 0; i < NR/2*WPR; i++) check_eq(tag, wget(base + i), gold_word(mode, i));
    endtask

    task automatic drain();
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int n;
        logic ok;
        rstn = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_full = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_in_ready", WW'(in_ready), 0);
        check_eq("rst_wren", WW'(out_wren), 0);
        check_eq("rst_din", out_din, 0);
        check_eq("rst_done", WW'({row_done, frame_done}), 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check_eq("post_rst_ready", WW'(in_ready), 1);
        check_eq("post_rst_state", WW'(dut.state_q), 0);

        // Ramp frame, no back-pressure.
        clear_obs();
        feed(0, FRAME_PIX, 0);
        drain();
        check_eq("ramp_count", WW'(words.size()), 100);
        check_eq("ramp_w0_hand", wget(0), {3{56'h3F3D3B39373533}});
        check_eq("ramp_w3_hand", wget(3), {3{56'h00000063615F5D}});
        check_frame("ramp", 0, 0);
        check_eq("ramp_rows", WW'(rd_cnt), 25);
        check_eq("ramp_frames", WW'(fd_cnt), 1);

        // Back-pressure on the first word.
        clear_obs();
        out_full = 1'b1;
        fork
            feed(0, FRAME_PIX, 0);
            begin
                n = 0;
                ok = 1'b1;
                do begin
                    @(negedge clk);
                    #1;
                    n++;
                end while (in_ready !== 1'b0 && n < 3000);
                check_eq("stall_seen", WW'(n < 3000), 1);
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    #1;
                    if (out_wren !== 1'b0 || in_ready !== 1'b0) ok = 1'b0;
                end
                check_eq("stall_quiet", WW'(ok), 1);
                check_eq("stall_no_early", WW'(words.size()), 0);
                @(posedge clk);
                #1;
                out_full = 1'b0;
                @(negedge clk);
                #1;
                check_eq("stall_release_wren", WW'(out_wren), 1);
                check_eq("stall_release_din", out_din, gold_word(0, 0));
            end
        join
        drain();
        check_eq("stall_count", WW'(words.size()), 100);
        check_frame("stall", 0, 0);

        // Random input gaps.
        clear_obs();
        feed(0, FRAME_PIX, 50);
        drain();
        check_eq("gap_count", WW'(words.size()), 100);
        check_frame("gap", 0, 0);

        // Lane independence.
        clear_obs();
        feed(1, FRAME_PIX, 0);
        drain();
        check_eq("lane_w0_hand", wget(0), {56'hC8C8C8C8C8C8C8, 56'h0, 56'hFFFFFFFFFFFFFF});
        check_frame("lane", 1, 0);

        // Two back-to-back frames with different content.
        clear_obs();
        feed(0, FRAME_PIX, 0);
        feed(1, FRAME_PIX, 0);
        drain();
        check_eq("two_count", WW'(words.size()), 200);
        check_frame("two_f0", 0, 0);
        check_frame("two_f1", 1, 100);
        check_eq("two_frames", WW'(fd_cnt), 2);
        check_eq("two_rows", WW'(rd_cnt), 50);
        check_eq("two_fd_align", WW'(fd_bad), 0);
        check_eq("two_fd0_row", WW'(fd_rd.size() > 0 ? fd_rd[0] : -1), 25);
        check_eq("two_fd1_row", WW'(fd_rd.size() > 1 ? fd_rd[1] : -1), 50);

        // Reset in the middle of an odd row.
        clear_obs();
        feed(0, RL + 20, 0);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_eq("midrst_wren", WW'(out_wren), 0);
        check_eq("midrst_ready", WW'(in_ready), 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check_eq("midrst_state", WW'(dut.state_q), 0);
        check_eq("midrst_ready_after", WW'(in_ready), 1);
        clear_obs();
        feed(0, FRAME_PIX, 0);
        drain();
        check_eq("midrst_count", WW'(words.size()), 100);
        check_frame("midrst", 0, 0);
        check_eq("midrst_frames", WW'(fd_cnt), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
